// File: rtl/mult_pkg.sv
// Shared constants and types for the multiplier / accumulator slice.
// Holds the accumulator width helper and the accumulator FSM state type.
package mult_pkg;

    localparam int MULT_N  = 8;
    localparam int MAC_LEN = 8;

    // Widest sum of len products of n-bit operands, without overflow.
    function automatic int acc_width(input int n, input int len);
        return 2 * n + $clog2(len);
    endfunction

    typedef enum logic {
        ACCUM,
        DONE
    } acc_state_t;

endpackage

// File: rtl/fast_adder.sv
// Parallel-prefix (Kogge-Stone) adder with carry-in and carry-out.
// Carry-in is folded into bit 0's generate so the prefix tree covers it.
module fast_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    localparam int LVL = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0] w_g;
    logic [W-1:0] w_p;
    logic [W-1:0] w_gg;
    logic [W-1:0] w_pp;
    logic [W-1:0] w_gn;
    logic [W-1:0] w_pn;
    logic [W-1:0] w_c;

    always_comb begin
        w_p    = i_a ^ i_b;
        w_g    = i_a & i_b;
        w_g[0] = w_g[0] | (w_p[0] & i_cin);
        w_gg   = w_g;
        w_pp   = w_p;
        w_gn   = w_g;
        w_pn   = w_p;
        for (int k = 0; k < LVL; k++) begin
            w_gn = w_gg;
            w_pn = w_pp;
            for (int i = (1 << k); i < W; i++) begin
                w_gn[i] = w_gg[i] | (w_pp[i] & w_gg[i - (1 << k)]);
                w_pn[i] = w_pp[i] & w_pp[i - (1 << k)];
            end
            w_gg = w_gn;
            w_pp = w_pn;
        end
        w_c    = '0;
        w_c[0] = i_cin;
        for (int i = 1; i < W; i++) begin
            w_c[i] = w_gg[i - 1];
        end
        o_sum  = w_p ^ w_c;
        o_cout = w_gg[W-1];
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums LEN unsigned products, then hands the total downstream via valid/ready.
// Define PRODUCT_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module product_accumulator
    import mult_pkg::*;
#(
    parameter int N     = MULT_N,
    parameter int LEN   = MAC_LEN,
    parameter int ACC_W = acc_width(MULT_N, MAC_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2*N-1:0]   i_p,
    input  logic             i_clear,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ACC_W-1:0] o_acc,
    output logic             o_overflow
);

    localparam int CNT_W = $clog2(LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    acc_state_t       r_state;
    acc_state_t       w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;

    logic [ACC_W-1:0] w_term;
    logic [ACC_W-1:0] w_sum;
    logic             w_cout;
    logic [ACC_W-1:0] w_add_res;
    logic             w_accept;

    assign w_term = ACC_W'(i_p);

    fast_adder #(
        .W(ACC_W)
    ) u_add (
        .i_a    (r_acc),
        .i_b    (w_term),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

`ifdef PRODUCT_ACC_SATURATE_EN
    // Once clamped, any further non-zero term carries out again.
    assign w_add_res = w_cout ? {ACC_W{1'b1}} : w_sum;
`else
    assign w_add_res = w_sum;
`endif

    assign w_accept = i_valid & o_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        unique case (r_state)
            ACCUM: begin
                o_ready = ~reset;
                if (i_clear) begin
                    w_acc_nxt = '0;
                    w_cnt_nxt = '0;
                    w_ovf_nxt = 1'b0;
                end else if (w_accept) begin
                    w_acc_nxt = w_add_res;
                    w_ovf_nxt = r_ovf | w_cout;
                    if (r_cnt == LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready | i_clear) begin
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = ACCUM;
                end
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign o_acc      = r_acc;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator (LEN=4, ACC_W=17).
// Expected values are hand-computed; overflow case follows the build macro.
module tb_product_accumulator;

    localparam int N     = 8;
    localparam int LEN   = 4;
    localparam int ACC_W = 17;

`ifdef PRODUCT_ACC_SATURATE_EN
    localparam int OVF_ACC = 131071;
`else
    localparam int OVF_ACC = 129028;
`endif

    logic             clk;
    logic             reset;
    logic             i_valid;
    logic             o_ready;
    logic [2*N-1:0]   i_p;
    logic             i_clear;
    logic             o_valid;
    logic             i_ready;
    logic [ACC_W-1:0] o_acc;
    logic             o_overflow;

    int checks;
    int errors;

    product_accumulator #(
        .N     (N),
        .LEN   (LEN),
        .ACC_W (ACC_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_p        (i_p),
        .i_clear    (i_clear),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_acc      (o_acc),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int v);
        i_valid = 1'b1;
        i_p     = 16'(v);
        tick();
        i_valid = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        i_valid = 1'b0;
        i_p     = '0;
        i_clear = 1'b0;
        i_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", int'(o_valid), 0);
        check("rst_acc", int'(o_acc), 0);
        check("rst_ovf", int'(o_overflow), 0);
        reset = 1'b0;
        #1;
        check("rst_ready", int'(o_ready), 1);

        // 1: reset mid-block
        feed(10);
        feed(20);
        check("mid_acc", int'(o_acc), 30);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", int'(o_valid), 0);
        check("arst_acc", int'(o_acc), 0);
        tick();
        reset = 1'b0;
        #1;
        feed(1); feed(1); feed(1); feed(1);
        check("t1_valid", int'(o_valid), 1);
        check("t1_acc", int'(o_acc), 4);
        tick();

        // 2: basic sum, single-cycle valid
        feed(6); feed(100); feed(65025);
        check("t2_pre", int'(o_valid), 0);
        feed(3);
        check("t2_valid", int'(o_valid), 1);
        check("t2_acc", int'(o_acc), 65134);
        check("t2_ovf", int'(o_overflow), 0);
        tick();
        check("t2_vdrop", int'(o_valid), 0);
        check("t2_clr", int'(o_acc), 0);

        // 3: backpressure
        i_ready = 1'b0;
        feed(6); feed(100); feed(65025); feed(3);
        i_valid = 1'b1;
        i_p     = 16'd500;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold", int'(o_acc), 65134);
            check("t3_rdy", int'(o_ready), 0);
            check("t3_vld", int'(o_valid), 1);
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        check("t3_done", int'(o_valid), 0);
        feed(1); feed(1); feed(1); feed(1);
        check("t3_next", int'(o_acc), 4);
        tick();

        // 4: bubbles
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            feed(7);
        end
        check("t4_valid", int'(o_valid), 1);
        check("t4_acc", int'(o_acc), 28);
        tick();

        // 5: clear beats a same-cycle term
        feed(50);
        i_clear = 1'b1;
        i_valid = 1'b1;
        i_p     = 16'd99;
        tick();
        i_clear = 1'b0;
        i_valid = 1'b0;
        check("t5_clr", int'(o_acc), 0);
        feed(1); feed(2); feed(3);
        check("t5_pre", int'(o_valid), 0);
        feed(4);
        check("t5_acc", int'(o_acc), 10);
        tick();

        // clear in DONE drops the pending result
        i_ready = 1'b0;
        feed(5); feed(5); feed(5); feed(5);
        check("dclr_valid", int'(o_valid), 1);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        i_ready = 1'b1;
        check("dclr_drop", int'(o_valid), 0);
        check("dclr_acc", int'(o_acc), 0);

        // 6: overflow
        feed(65025); feed(65025);
        check("t6_noovf", int'(o_overflow), 0);
        feed(65025);
        check("t6_midovf", int'(o_overflow), 1);
        feed(65025);
        check("t6_acc", int'(o_acc), OVF_ACC);
        check("t6_ovf", int'(o_overflow), 1);
        tick();
        check("t6_ovfclr", int'(o_overflow), 0);
        feed(1); feed(1); feed(1); feed(1);
        check("t6_next", int'(o_acc), 4);
        check("t6_nxtovf", int'(o_overflow), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
